// File: rtl/led_mode_ctrl.sv
// LED mode controller: synchronises and debounces one push-button, steps a
// four-state mode FSM per press, and drops back to OFF after an idle timeout.
module led_mode_ctrl #(
  parameter logic [19:0] DEB_MAX          = 20'd999_999,
  parameter logic [31:0] SEC_MAX          = 32'd49_999_999,
  parameter logic [7:0]  IDLE_TIMEOUT_SEC = 8'd30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic [1:0] mode,
  output logic [2:0] mode_en,
  output logic       key_pulse
);

  typedef enum logic [1:0] {OFF = 2'b00, FLASH = 2'b01, CHASE = 2'b10, ON = 2'b11} mode_t;

  mode_t       state, state_nxt;
  logic [2:0]  en_nxt;
  logic        key_m, key_s, key_db;
  logic [19:0] deb_cnt;
  logic [31:0] sec_cnt;
  logic [7:0]  idle_sec;
  logic        deb_hit, sec_tick, timeout;

  assign deb_hit  = (key_s != key_db) && (deb_cnt == DEB_MAX);
  assign sec_tick = (sec_cnt == SEC_MAX);
  assign timeout  = (IDLE_TIMEOUT_SEC != 8'd0) && (idle_sec == IDLE_TIMEOUT_SEC) && (state != OFF);

  // sync chain and debounced level reset high so rst release is never a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
    end else begin
      key_m <= key_n;
      key_s <= key_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_db    <= 1'b1;
      deb_cnt   <= 20'd0;
      key_pulse <= 1'b0;
    end else begin
      key_pulse <= deb_hit & ~key_s;
      if (key_s == key_db) begin
        deb_cnt <= 20'd0;
      end else if (deb_hit) begin
        key_db  <= key_s;
        deb_cnt <= 20'd0;
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt  <= 32'd0;
      idle_sec <= 8'd0;
    end else if (key_pulse || state == OFF || timeout) begin
      sec_cnt  <= 32'd0;
      idle_sec <= 8'd0;
    end else begin
      sec_cnt <= sec_tick ? 32'd0 : sec_cnt + 32'd1;
      if (sec_tick && idle_sec != IDLE_TIMEOUT_SEC) idle_sec <= idle_sec + 8'd1;
    end
  end

  // a press takes priority over a timeout landing in the same cycle
  always_comb begin
    state_nxt = state;
    if (key_pulse) begin
      case (state)
        OFF:     state_nxt = FLASH;
        FLASH:   state_nxt = CHASE;
        CHASE:   state_nxt = ON;
        default: state_nxt = OFF;
      endcase
    end else if (timeout) begin
      state_nxt = OFF;
    end
  end

  always_comb begin
    en_nxt = 3'b000;
    case (state_nxt)
      FLASH:   en_nxt = 3'b001;
      CHASE:   en_nxt = 3'b010;
      ON:      en_nxt = 3'b100;
      default: en_nxt = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= OFF;
      mode_en <= 3'b000;
    end else begin
      state   <= state_nxt;
      mode_en <= en_nxt;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl: stimulus queues expected mode changes,
// a negedge monitor pops and checks each change the DUT presents.
module tb_led_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_n = 1'b1;
  logic [1:0] mode;
  logic [2:0] mode_en;
  logic       key_pulse;

  led_mode_ctrl #(.DEB_MAX(20'd4), .SEC_MAX(32'd9), .IDLE_TIMEOUT_SEC(8'd3)) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .mode(mode), .mode_en(mode_en), .key_pulse(key_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] en;
    logic       by_pulse;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   last_pulse_cyc = 0;
  int   last_chg_cyc = 0;
  logic [1:0] prev_mode = 2'b00;
  logic       prev_pulse = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] m, input logic [2:0] e, input logic p);
    exp_t x;
    x.mode = m; x.en = e; x.by_pulse = p;
    exp_q.push_back(x);
  endtask

  task automatic press(input int lo, input int hi);
    key_n = 1'b0;
    repeat (lo) @(negedge clk);
    key_n = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (key_pulse === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      chk("pulse_width", int'(prev_pulse), 0);
    end
    if (mode !== prev_mode) begin
      last_chg_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_mode_change", int'(mode), int'(prev_mode));
      end else begin
        e = exp_q.pop_front();
        chk("mode", int'(mode), int'(e.mode));
        chk("mode_en", int'(mode_en), int'(e.en));
        chk("change_after_pulse", int'(prev_pulse), int'(e.by_pulse));
      end
    end
    prev_mode  = mode;
    prev_pulse = key_pulse;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int f, r, p0;
    // 1: reset with idle key
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mode", int'(mode), 0);
    chk("rst_mode_en", int'(mode_en), 0);
    chk("rst_pulse", int'(key_pulse), 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_pulses", pulse_cnt, 0);
    chk("idle_mode", int'(mode), 0);

    // 2: long press -> FLASH, then idle timeout back to OFF
    push(2'b01, 3'b001, 1'b1);
    push(2'b00, 3'b000, 1'b0);
    p0 = pulse_cnt;
    f = cyc;
    press(20, 12);
    chk("first_pulse_latency", last_pulse_cyc - f, 7);
    chk("first_pulse_count", pulse_cnt - p0, 1);
    repeat (20) @(negedge clk);
    chk("first_timeout_mode", int'(mode), 0);

    // 3: four presses cycle through every mode
    push(2'b01, 3'b001, 1'b1);
    push(2'b10, 3'b010, 1'b1);
    push(2'b11, 3'b100, 1'b1);
    push(2'b00, 3'b000, 1'b1);
    p0 = pulse_cnt;
    repeat (4) press(10, 10);
    chk("cycle_pulse_count", pulse_cnt - p0, 4);

    // 4: short glitch ignored, bounce then steady low gives one press
    p0 = pulse_cnt;
    press(3, 15);
    chk("glitch_pulse_count", pulse_cnt - p0, 0);
    chk("glitch_mode", int'(mode), 0);
    push(2'b01, 3'b001, 1'b1);
    push(2'b00, 3'b000, 1'b0);
    p0 = pulse_cnt;
    press(2, 2);
    press(2, 2);
    press(12, 10);
    chk("bounce_pulse_count", pulse_cnt - p0, 1);
    repeat (45) @(negedge clk);

    // 5a: timeout latency from the entering pulse
    push(2'b01, 3'b001, 1'b1);
    push(2'b00, 3'b000, 1'b0);
    press(10, 10);
    repeat (30) @(negedge clk);
    chk("timeout_latency", last_chg_cyc - last_pulse_cyc, 32);
    chk("timeout_mode", int'(mode), 0);

    // 5b: second press lands exactly in the timeout cycle
    push(2'b01, 3'b001, 1'b1);
    push(2'b10, 3'b010, 1'b1);
    f = cyc;
    key_n = 1'b0;
    repeat (10) @(negedge clk);
    key_n = 1'b1;
    repeat (21) @(negedge clk);
    key_n = 1'b0;
    repeat (12) @(negedge clk);
    chk("race_pulse_cyc", last_pulse_cyc - f, 38);
    chk("race_mode", int'(mode), 2);

    // 6: reset in CHASE with key held low
    push(2'b00, 3'b000, 1'b0);
    push(2'b01, 3'b001, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_mode", int'(mode), 0);
    chk("async_rst_mode_en", int'(mode_en), 0);
    chk("async_rst_pulse", int'(key_pulse), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r = cyc;
    p0 = pulse_cnt;
    repeat (12) @(negedge clk);
    chk("post_rst_pulse_count", pulse_cnt - p0, 1);
    chk("post_rst_pulse_latency", last_pulse_cyc - r, 7);
    push(2'b00, 3'b000, 1'b0);
    key_n = 1'b1;
    repeat (45) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Mode controller for the LED system. It debounces one raw push-button, steps a 4-state mode FSM on each clean press, and drives one-hot enables to the LED effect sub-blocks: bit0 goes to the flash blinker's system_en, bit1 to the chase block, bit2 to the all-on driver. An inactivity timeout returns the system to OFF.

Parameters:
DEB_MAX, 20'd999_999, debounce settle count in clk cycles; default is 20 ms at 50 MHz.
SEC_MAX, 32'd49_999_999, clk cycles per 1 s tick minus 1.
IDLE_TIMEOUT_SEC, 8'd30, whole seconds without a press before forcing OFF. Value 0 disables the timeout.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
key_n  input  1  raw button, active-low, asynchronous to clk.
mode  output  2  current mode: 00 OFF, 01 FLASH, 10 CHASE, 11 ON.
mode_en  output  3  one-hot sub-block enables. OFF=000, FLASH=001, CHASE=010, ON=100.
key_pulse  output  1  one-cycle strobe per debounced press.

Behaviour:
- Reset: asynchronous on rst=1.
  - Outputs: mode=00, mode_en=000, key_pulse=0.
  - Internal: sync FFs=1, debounced level=1, all counters=0.
  - No spurious press may be produced when rst releases with key_n=1.
- Synchroniser: key_n passes through 2 FFs to give key_s.
- Debounce counter:
  - deb_cnt increments while key_s != debounced level.
  - deb_cnt clears to 0 whenever key_s == debounced level.
  - When deb_cnt reaches DEB_MAX while still mismatched: the debounced level takes key_s and deb_cnt clears.
  - A glitch shorter than DEB_MAX+1 cycles changes nothing.
- Press detect: key_pulse=1 for exactly one cycle, in the cycle after the debounced level goes 1->0. Release (0->1) produces no pulse.
- FSM:
  - Registered states OFF->FLASH->CHASE->ON->OFF. Advances one step per key_pulse.
  - mode and mode_en are registered and update in the cycle after key_pulse.
  - mode_en is always the decode of mode. Never more than one bit set.
- Timeout counters:
  - sec_cnt counts 0..SEC_MAX and wraps, giving a one-cycle sec_tick at SEC_MAX.
  - idle_sec increments on sec_tick, saturating at IDLE_TIMEOUT_SEC.
  - Both counters clear on key_pulse, and are held at 0 while mode=OFF.
- Timeout action: when idle_sec==IDLE_TIMEOUT_SEC (nonzero) and mode!=OFF:
  - Next cycle mode=00 and mode_en=000.
  - Counters clear.
- Simultaneous key_pulse and timeout in the same cycle: the press wins. The FSM advances from the current mode and the counters clear.
- Counter widths: deb_cnt 20 bits, sec_cnt 32 bits, idle_sec 8 bits. Compares are exact-equality.
- Downstream contract: a sub-block whose enable drops to 0 holds its LED off (led=1) immediately. This block imposes no extra delay on that.

Test Plan (bench parameters DEB_MAX=4, SEC_MAX=9, IDLE_TIMEOUT_SEC=3):
1. Reset, key_n=1 held 100 cycles -> mode=00, mode_en=000, key_pulse never 1.
2. key_n low 20 cycles then high -> exactly one key_pulse, about 7 cycles after the falling edge (2 sync + 5 debounce). The next cycle mode=01, mode_en=001. Release gives no pulse.
3. Four clean presses in turn -> mode sequence 01, 10, 11, 00 and mode_en 001, 010, 100, 000, with exactly one key_pulse per press.
4. key_n glitched low for 3 cycles -> no key_pulse, mode unchanged. Separately, bounce 1-0-1-0 every 2 cycles then a steady 0 -> exactly one key_pulse.
5. Enter FLASH, then no press -> mode returns to 00 one cycle after idle_sec reaches 3 (about 30 cycles after the entering key_pulse). A press arriving in the timeout cycle -> mode=10 and no return to OFF.
6. Assert rst in CHASE while key_n=0 -> outputs go to 0 immediately. After release with key_n still 0 -> one key_pulse after debounce, then mode=01.
